dmp_stream_tx: RTL and testbench

Transmit side of the DMP partial-PageRank stream. Collects one partial-contribution vector per hardware thread for each iteration. Serializes the vectors, one thread per beat in thread-index order, onto the stream consumed by the final damping/accumulate stage. Frames each iteration with stream_start and stream_done, uses a valid/ready handshake with the sink, and acknowledges each thread once its vector has been taken.

---
 rtl/dmp_stream_tx.sv | 125 ++++++++++++
 tb/tb_dmp_stream_tx.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmp_stream_tx.sv
// dmp_stream_tx: serializes per-thread partial PageRank vectors onto a valid/ready
// stream, one thread per beat in index order, framed by stream_start/stream_done.
`default_nettype none

module dmp_stream_tx #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32,
  localparam int TID_W = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1
) (
  input  logic                                               clock,
  input  logic                                               reset_n,
  input  logic                                               iteration_start,
  input  logic [NUM_HW_THREADS-1:0]                          thread_valid,
  input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][63:0] thread_partial,
  output logic [NUM_HW_THREADS-1:0]                          thread_ack,
  output logic [NODES_IN_GRAPH-1:0][63:0]                    pagerank_serial_stream,
  output logic                                               stream_valid,
  input  logic                                               stream_ready,
  output logic                                               stream_start,
  output logic                                               stream_done,
  output logic [TID_W-1:0]                                   stream_thread_id,
  output logic                                               busy,
  output logic                                               tx_iteration_complete
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [TID_W-1:0] LAST_IDX = TID_W'(NUM_HW_THREADS - 1);

  state_t                           state;
  logic [TID_W-1:0]                 idx;
  logic                             slot_free;
  logic                             sel_valid;
  logic [NODES_IN_GRAPH-1:0][63:0]  sel_data;
  logic [NUM_HW_THREADS-1:0]        sel_onehot;

  // Explicit compare-and-select keeps the thread mux width-clean for any thread count.
  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int t = 0; t < NUM_HW_THREADS; t++) begin
      if (idx == TID_W'(t)) begin
        sel_valid     = thread_valid[t];
        sel_data      = thread_partial[t];
        sel_onehot[t] = 1'b1;
      end
    end
  end

  assign slot_free = !stream_valid || stream_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      idx                    <= '0;
      thread_ack             <= '0;
      pagerank_serial_stream <= '0;
      stream_valid           <= 1'b0;
      stream_start           <= 1'b0;
      stream_done            <= 1'b0;
      stream_thread_id       <= '0;
      busy                   <= 1'b0;
      tx_iteration_complete  <= 1'b0;
    end else begin
      thread_ack            <= '0;
      tx_iteration_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (iteration_start) begin
            state <= SEND;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SEND: begin
          if (slot_free) begin
            if (sel_valid) begin
              pagerank_serial_stream <= sel_data;
              stream_valid           <= 1'b1;
              stream_thread_id       <= idx;
              stream_start           <= (idx == '0);
              stream_done            <= (idx == LAST_IDX);
              thread_ack             <= sel_onehot;
              if (idx == LAST_IDX) begin
                state <= DRAIN;
              end else begin
                idx <= idx + TID_W'(1);
              end
            end else if (stream_valid) begin
              // Beat taken with nothing to follow: framing is zeroed while the stream is empty.
              stream_valid     <= 1'b0;
              stream_start     <= 1'b0;
              stream_done      <= 1'b0;
              stream_thread_id <= '0;
            end
          end
        end
        DRAIN: begin
          if (stream_ready) begin
            stream_valid          <= 1'b0;
            stream_start          <= 1'b0;
            stream_done           <= 1'b0;
            stream_thread_id      <= '0;
            tx_iteration_complete <= 1'b1;
            state                 <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmp_stream_tx.sv
// Self-checking bench for dmp_stream_tx: a 4-thread instance for ordering,
// backpressure, gaps and reset, plus a 1-thread instance for combined framing.
`timescale 1ns/1ps
`default_nettype none

module tb_dmp_stream_tx;

  localparam int NT = 4;
  localparam int NN = 4;

  typedef logic [NN-1:0][63:0] vec_t;
  typedef struct {
    logic [1:0] tid;
    vec_t       data;
    logic       start;
    logic       done;
  } beat_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic                   iteration_start = 1'b0;
  logic [NT-1:0]          thread_valid = '0;
  logic [NT-1:0][NN-1:0][63:0] thread_partial = '0;
  logic [NT-1:0]          thread_ack;
  vec_t                   pagerank_serial_stream;
  logic                   stream_valid;
  logic                   stream_ready = 1'b0;
  logic                   stream_start;
  logic                   stream_done;
  logic [1:0]             stream_thread_id;
  logic                   busy;
  logic                   tx_iteration_complete;

  logic                   iteration_start_s = 1'b0;
  logic [0:0]             thread_valid_s = '0;
  logic [0:0][NN-1:0][63:0] thread_partial_s = '0;
  logic [0:0]             thread_ack_s;
  vec_t                   data_s;
  logic                   valid_s;
  logic                   ready_s = 1'b0;
  logic                   start_s;
  logic                   done_s;
  logic [0:0]             tid_s;
  logic                   busy_s;
  logic                   complete_s;

  dmp_stream_tx #(.NUM_HW_THREADS(NT), .NODES_IN_GRAPH(NN)) dut (
    .clock(clock), .reset_n(reset_n), .iteration_start(iteration_start),
    .thread_valid(thread_valid), .thread_partial(thread_partial),
    .thread_ack(thread_ack), .pagerank_serial_stream(pagerank_serial_stream),
    .stream_valid(stream_valid), .stream_ready(stream_ready),
    .stream_start(stream_start), .stream_done(stream_done),
    .stream_thread_id(stream_thread_id), .busy(busy),
    .tx_iteration_complete(tx_iteration_complete)
  );

  dmp_stream_tx #(.NUM_HW_THREADS(1), .NODES_IN_GRAPH(NN)) dut_single (
    .clock(clock), .reset_n(reset_n), .iteration_start(iteration_start_s),
    .thread_valid(thread_valid_s), .thread_partial(thread_partial_s),
    .thread_ack(thread_ack_s), .pagerank_serial_stream(data_s),
    .stream_valid(valid_s), .stream_ready(ready_s),
    .stream_start(start_s), .stream_done(done_s),
    .stream_thread_id(tid_s), .busy(busy_s),
    .tx_iteration_complete(complete_s)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  beat_t sb[$];

  function automatic vec_t mk(input int t, input int tag);
    vec_t v;
    for (int n = 0; n < NN; n++) v[n] = (64'(tag) << 32) | 64'(t * 16 + n);
    return v;
  endfunction

  task automatic load_iter(input int tag);
    beat_t b;
    for (int t = 0; t < NT; t++) begin
      thread_partial[t] = mk(t, tag);
      b.tid   = 2'(t);
      b.data  = mk(t, tag);
      b.start = (t == 0);
      b.done  = (t == NT - 1);
      sb.push_back(b);
    end
  endtask

  task automatic pulse_start;
    @(negedge clock) iteration_start = 1'b1;
    @(negedge clock) iteration_start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    n_checks++;
    if ({stream_valid, stream_start, stream_done, stream_thread_id, thread_ack, busy,
         tx_iteration_complete, pagerank_serial_stream} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b s=%b d=%b id=%0d ack=%b busy=%b cmp=%b data=%h, required all zero",
               stream_valid, stream_start, stream_done, stream_thread_id, thread_ack, busy,
               tx_iteration_complete, pagerank_serial_stream);
    end
    n_checks++;
    if ({valid_s, start_s, done_s, tid_s, thread_ack_s, busy_s, complete_s, data_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_state_single: v=%b busy=%b data=%h, required all zero", valid_s, busy_s, data_s);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int next_ack = 0, n_done = 0, first_hs = -1, last_hs = -1, done_c = -1;
    beat_t b;
    load_iter(1);
    thread_valid = '1;
    stream_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      // Start in the DONE cycle must not launch a new iteration.
      iteration_start = tx_iteration_complete;
      if (thread_ack !== '0) begin
        n_checks++;
        if (thread_ack !== 4'(1 << next_ack) || stream_thread_id !== 2'(next_ack)) begin
          n_fail++;
          $display("FAIL basic_ack: got ack=%b id=%0d, required ack for thread %0d", thread_ack, stream_thread_id, next_ack);
        end
        next_ack++;
      end
      if (stream_valid && stream_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL basic_extra_beat: got id=%0d, required no beat", stream_thread_id);
        end else begin
          b = sb.pop_front();
          if (pagerank_serial_stream !== b.data || stream_thread_id !== b.tid ||
              stream_start !== b.start || stream_done !== b.done) begin
            n_fail++;
            $display("FAIL basic_beat: got id=%0d s=%b d=%b data=%h, required id=%0d s=%b d=%b data=%h",
                     stream_thread_id, stream_start, stream_done, pagerank_serial_stream, b.tid, b.start, b.done, b.data);
          end
        end
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (tx_iteration_complete) begin n_done++; done_c = c; end
    end
    iteration_start = 1'b0;
    thread_valid = '0;
    n_checks++;
    if (first_hs != 0 || last_hs != 3) begin
      n_fail++;
      $display("FAIL basic_throughput: got beats at cycles %0d..%0d, required 0..3", first_hs, last_hs);
    end
    n_checks++;
    if (n_done != 1 || done_c != 4) begin
      n_fail++;
      $display("FAIL basic_complete: got %0d pulses last at cycle %0d, required 1 at cycle 4", n_done, done_c);
    end
    n_checks++;
    if (sb.size() != 0 || next_ack != NT || busy !== 1'b0 || stream_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got pending=%0d acks=%0d busy=%b valid=%b, required 0 4 0 0", sb.size(), next_ack, busy, stream_valid);
    end
  endtask

  task automatic test_backpressure;
    int next_ack = 0, n_done = 0, stalls = 0;
    beat_t b;
    load_iter(2);
    thread_valid = '1;
    stream_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      stream_ready = !(stream_valid && stream_thread_id == 2'd1 && stalls < 3);
      if (!stream_ready) begin
        stalls++;
        n_checks++;
        if (sb.size() == 0 || pagerank_serial_stream !== sb[0].data || stream_thread_id !== 2'd1 || thread_ack[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold: got id=%0d ack=%b data=%h, required id=1 no ack[2] data held", stream_thread_id, thread_ack, pagerank_serial_stream);
        end
      end
      if (thread_ack !== '0) begin
        n_checks++;
        if (thread_ack !== 4'(1 << next_ack) || stream_thread_id !== 2'(next_ack)) begin
          n_fail++;
          $display("FAIL bp_ack: got ack=%b id=%0d, required ack for thread %0d", thread_ack, stream_thread_id, next_ack);
        end
        next_ack++;
      end
      if (stream_valid && stream_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_beat: got id=%0d, required no beat", stream_thread_id);
        end else begin
          b = sb.pop_front();
          if (pagerank_serial_stream !== b.data || stream_thread_id !== b.tid ||
              stream_start !== b.start || stream_done !== b.done) begin
            n_fail++;
            $display("FAIL bp_beat: got id=%0d s=%b d=%b, required id=%0d s=%b d=%b",
                     stream_thread_id, stream_start, stream_done, b.tid, b.start, b.done);
          end
        end
      end
      if (tx_iteration_complete) n_done++;
    end
    stream_ready = 1'b1;
    thread_valid = '0;
    n_checks++;
    if (stalls != 3 || sb.size() != 0 || n_done != 1 || next_ack != NT) begin
      n_fail++;
      $display("FAIL bp_end: got stalls=%0d pending=%0d done=%0d acks=%0d, required 3 0 1 4", stalls, sb.size(), n_done, next_ack);
    end
  endtask

  task automatic test_out_of_order;
    int next_ack = 0, n_done = 0;
    beat_t b;
    load_iter(3);
    thread_valid = 4'b0100;
    stream_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      iteration_start = (c == 1);
      if (c == 4) thread_valid = '1;
      if (c == 3) begin
        n_checks++;
        if (stream_valid !== 1'b0 || thread_ack !== '0) begin
          n_fail++;
          $display("FAIL ooo_wait: got valid=%b ack=%b, required 0 and 0000", stream_valid, thread_ack);
        end
      end
      if (thread_ack !== '0) begin
        n_checks++;
        if (thread_ack !== 4'(1 << next_ack) || stream_thread_id !== 2'(next_ack)) begin
          n_fail++;
          $display("FAIL ooo_ack: got ack=%b id=%0d, required ack for thread %0d", thread_ack, stream_thread_id, next_ack);
        end
        next_ack++;
      end
      if (stream_valid && stream_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL ooo_extra_beat: got id=%0d, required no beat", stream_thread_id);
        end else begin
          b = sb.pop_front();
          if (pagerank_serial_stream !== b.data || stream_thread_id !== b.tid ||
              stream_start !== b.start || stream_done !== b.done) begin
            n_fail++;
            $display("FAIL ooo_beat: got id=%0d s=%b d=%b, required id=%0d s=%b d=%b",
                     stream_thread_id, stream_start, stream_done, b.tid, b.start, b.done);
          end
        end
      end
      if (tx_iteration_complete) n_done++;
    end
    iteration_start = 1'b0;
    thread_valid = '0;
    n_checks++;
    if (sb.size() != 0 || n_done != 1 || next_ack != NT || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_end: got pending=%0d done=%0d acks=%0d busy=%b, required 0 1 4 0", sb.size(), n_done, next_ack, busy);
    end
  endtask

  task automatic test_gap;
    int next_ack = 0, n_done = 0;
    beat_t b;
    load_iter(4);
    thread_valid = 4'b1101;
    stream_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c == 3) thread_valid = '1;
      if (c == 1) begin
        n_checks++;
        if (stream_valid !== 1'b0 || stream_thread_id !== 2'd0 || stream_start !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_drop: got valid=%b id=%0d s=%b, required 0 0 0", stream_valid, stream_thread_id, stream_start);
        end
      end
      if (thread_ack !== '0) begin
        n_checks++;
        if (thread_ack !== 4'(1 << next_ack) || stream_thread_id !== 2'(next_ack)) begin
          n_fail++;
          $display("FAIL gap_ack: got ack=%b id=%0d, required ack for thread %0d", thread_ack, stream_thread_id, next_ack);
        end
        next_ack++;
      end
      if (stream_valid && stream_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL gap_extra_beat: got id=%0d, required no beat", stream_thread_id);
        end else begin
          b = sb.pop_front();
          if (pagerank_serial_stream !== b.data || stream_thread_id !== b.tid ||
              stream_start !== b.start || stream_done !== b.done) begin
            n_fail++;
            $display("FAIL gap_beat: got id=%0d s=%b d=%b, required id=%0d s=%b d=%b",
                     stream_thread_id, stream_start, stream_done, b.tid, b.start, b.done);
          end
        end
      end
      if (tx_iteration_complete) n_done++;
    end
    thread_valid = '0;
    n_checks++;
    if (sb.size() != 0 || n_done != 1 || next_ack != NT) begin
      n_fail++;
      $display("FAIL gap_end: got pending=%0d done=%0d acks=%0d, required 0 1 4", sb.size(), n_done, next_ack);
    end
  endtask

  task automatic test_single_thread;
    int n_beats = 0, n_done = 0;
    thread_partial_s[0] = mk(0, 9);
    thread_valid_s = 1'b1;
    ready_s = 1'b1;
    @(negedge clock) iteration_start_s = 1'b1;
    @(negedge clock) iteration_start_s = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      iteration_start_s = (c == 0);
      if (valid_s && ready_s) begin
        n_beats++;
        n_checks++;
        if (data_s !== mk(0, 9) || start_s !== 1'b1 || done_s !== 1'b1 || tid_s !== 1'b0 || thread_ack_s !== 1'b1) begin
          n_fail++;
          $display("FAIL single_beat: got s=%b d=%b id=%0d ack=%b data=%h, required s=1 d=1 id=0 ack=1 data=%h",
                   start_s, done_s, tid_s, thread_ack_s, data_s, mk(0, 9));
        end
      end
      if (complete_s) n_done++;
    end
    iteration_start_s = 1'b0;
    thread_valid_s = 1'b0;
    n_checks++;
    if (n_beats != 1 || n_done != 1 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got beats=%0d done=%0d busy=%b, required 1 1 0", n_beats, n_done, busy_s);
    end
  endtask

  task automatic test_reset_mid;
    int next_ack = 0, n_done = 0, hit = 0;
    beat_t b;
    load_iter(5);
    thread_valid = '1;
    stream_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (stream_valid && stream_thread_id == 2'd2) begin
        #2 reset_n = 1'b0;
        #1;
        hit = 1;
        n_checks++;
        if ({stream_valid, stream_start, stream_done, stream_thread_id, thread_ack, busy,
             tx_iteration_complete, pagerank_serial_stream} !== '0) begin
          n_fail++;
          $display("FAIL async_reset: got v=%b id=%0d ack=%b busy=%b data=%h, required all zero",
                   stream_valid, stream_thread_id, thread_ack, busy, pagerank_serial_stream);
        end
        break;
      end
      if (stream_valid && stream_ready && sb.size() != 0) b = sb.pop_front();
    end
    n_checks++;
    if (hit != 1) begin
      n_fail++;
      $display("FAIL reset_reach_beat2: got hit=%0d, required 1", hit);
    end
    sb.delete();
    @(negedge clock) reset_n = 1'b1;
    load_iter(6);
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (thread_ack !== '0) begin
        n_checks++;
        if (thread_ack !== 4'(1 << next_ack) || stream_thread_id !== 2'(next_ack)) begin
          n_fail++;
          $display("FAIL restart_ack: got ack=%b id=%0d, required ack for thread %0d", thread_ack, stream_thread_id, next_ack);
        end
        next_ack++;
      end
      if (stream_valid && stream_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL restart_extra_beat: got id=%0d, required no beat", stream_thread_id);
        end else begin
          b = sb.pop_front();
          if (pagerank_serial_stream !== b.data || stream_thread_id !== b.tid ||
              stream_start !== b.start || stream_done !== b.done) begin
            n_fail++;
            $display("FAIL restart_beat: got id=%0d s=%b d=%b data=%h, required id=%0d s=%b d=%b data=%h",
                     stream_thread_id, stream_start, stream_done, pagerank_serial_stream, b.tid, b.start, b.done, b.data);
          end
        end
      end
      if (tx_iteration_complete) n_done++;
    end
    thread_valid = '0;
    n_checks++;
    if (sb.size() != 0 || n_done != 1 || next_ack != NT) begin
      n_fail++;
      $display("FAIL restart_end: got pending=%0d done=%0d acks=%0d, required 0 1 4", sb.size(), n_done, next_ack);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_out_of_order();
    test_gap();
    test_single_thread();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
